mem_port_arbiter: RTL and testbench
===================================

Name: mem_port_arbiter

Overview:
- Shares one single-ported unified memory between the pipelined CPU's instruction-fetch port (Pc/Inst) and its data port (MemAdr/MemReadData/MemWriteData, MemoryRead/MemoryWrite).
- Serialises accesses over a req/ack memory handshake and stalls the whole pipeline until every access requested in the current cycle has completed.
- Sits between the Cpu top and the memory model, in the system top.

Parameters:
- ADDR_W, 32, address width.
- DATA_W, 32, data width.
- TIMEOUT, 64, cycles without mem_ack before an access is abandoned and err is raised.

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  asynchronous, active-low reset.
- if_req  in  1  instruction fetch requested; held by the CPU while stalled.
- if_addr  in  ADDR_W  fetch address (Pc).
- if_rdata  out  DATA_W  fetched instruction, held until the next fetch completes.
- d_read  in  1  data read requested (MemoryRead).
- d_write  in  1  data write requested (MemoryWrite).
- d_addr  in  ADDR_W  data address (MemAdr).
- d_wdata  in  DATA_W  write data.
- d_rdata  out  DATA_W  read data, held until the next read completes.
- cpu_stall  out  1  freezes PC and all pipeline registers.
- mem_req  out  1  memory request, registered.
- mem_we  out  1  write enable, registered.
- mem_addr  out  ADDR_W  registered address.
- mem_wdata  out  DATA_W  registered write data.
- mem_rdata  in  DATA_W  memory read data, valid with mem_ack.
- mem_ack  in  1  one-cycle completion pulse.
- err  out  1  sticky timeout flag.

Behaviour:
- Reset (rst=0, asynchronous): state IDLE; mem_req=0, mem_we=0, mem_addr=0, mem_wdata=0; if_rdata=0, d_rdata=0; if_done=0, d_done=0; err=0; watchdog=0. An in-flight access is dropped, and mem_req falls without waiting for a clock.
- dop = d_read | d_write. If both are high, the access is a write.
- cpu_stall is combinational: (if_req & ~if_done) | (dop & ~d_done).
- On any rising edge with cpu_stall=0, if_done and d_done clear, because the CPU advances.
- FSM states: IDLE, D_BUSY, I_BUSY.
- Grant from IDLE: dop & ~d_done goes to D_BUSY. Otherwise if_req & ~if_done goes to I_BUSY. Data wins because it is the older instruction.
- On grant, mem_addr, mem_we and mem_wdata are latched (mem_wdata = d_wdata for writes, don't-care otherwise), and mem_req=1 from the next cycle. These are held stable until mem_ack.
- D_BUSY with mem_ack:
  - mem_req drops the next cycle and d_done is set.
  - On a read, d_rdata <= mem_rdata.
  - Next state is I_BUSY if if_req & ~if_done (alternation, no starvation), else IDLE.
- I_BUSY with mem_ack:
  - if_rdata <= mem_rdata and if_done is set.
  - Next state is D_BUSY if dop & ~d_done, else IDLE.
- Back-to-back grants issue a new mem_req on the cycle after the ack, so mem_req shows a one-cycle gap, not a merge.
- Latency: fastest access (ack one cycle after mem_req rises) stalls the CPU for 3 cycles. Both accesses in one cycle stall it for about 6 cycles.
- Watchdog:
  - Counts cycles in D_BUSY or I_BUSY without ack, and clears on ack or grant.
  - On reaching TIMEOUT: err <= 1 (sticky), the side's done flag is set (its data register is unchanged), the FSM returns to IDLE and mem_req drops. This prevents a permanent stall.
- mem_ack while in IDLE is ignored.
- Request lines are sampled only at grant; changes while busy have no effect until the next grant.
- d_rdata and if_rdata never change except on an ack for their own side.

Decomposition:
- Package cpu_mem_pkg holds:
  - the state enum (IDLE, D_BUSY, I_BUSY);
  - the default widths;
  - the TIMEOUT default.
- Sub-module ack_watchdog: counter with clear/enable inputs and an expired output, parameterised by TIMEOUT.
- The FSM, done flags and data registers stay in mem_port_arbiter.

Test Plan:
- Reset mid-access: assert rst=0 while mem_req=1 and if_addr=0x40. mem_req falls immediately, all outputs are 0, and state is IDLE after release.
- Fetch only: if_req=1, if_addr=0x10, memory acks 1 cycle after req with 0x8C010004. Expect mem_addr=0x10, mem_we=0, if_rdata=0x8C010004, and cpu_stall high for exactly 3 cycles.
- Both requests: if_req=1 (0x20) and d_read=1 (0x100), ack latency 2. Data is served first (mem_addr=0x100), then fetch (0x20). d_rdata=0xDEADBEEF, if_rdata=0x00221820, and cpu_stall stays high until both are done.
- Write: d_write=1, d_addr=0x200, d_wdata=0x12345678, plus if_req. Expect mem_we=1 with those values held stable until ack, d_rdata unchanged, then the fetch issues.
- Read and write both high with d_addr=0x300: treated as a write, mem_we=1.
- Timeout: never ack with TIMEOUT=8. After 8 busy cycles err=1, mem_req=0 and the stall releases. err stays 1 through later successful accesses until rst.

Source files
------------

// File: rtl/cpu_mem_pkg.sv
// Shared types and defaults for the CPU memory-port arbiter.
// Imported by the arbiter and its watchdog.
package cpu_mem_pkg;

  localparam int ADDR_W_DEF  = 32;
  localparam int DATA_W_DEF  = 32;
  localparam int TIMEOUT_DEF = 64;

  typedef enum logic [1:0] {
    IDLE,
    D_BUSY,
    I_BUSY
  } arb_state_t;

endpackage

// File: rtl/ack_watchdog.sv
// Counts busy cycles without a memory ack.
// expired pulses on the TIMEOUT-th such cycle.
module ack_watchdog
  import cpu_mem_pkg::*;
#(
  parameter int TIMEOUT = TIMEOUT_DEF
) (
  input  logic clk,
  input  logic rst,
  input  logic clr,
  input  logic en,
  output logic expired
);

  localparam int CW = $clog2(TIMEOUT + 1);

  logic [CW-1:0] cnt;

  assign expired = en & ~clr &
                   (cnt == CW'(TIMEOUT - 1));

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt <= '0;
    end else if (clr || expired) begin
      cnt <= '0;
    end else if (en) begin
      cnt <= cnt + CW'(1);
    end
  end

endmodule

// File: rtl/mem_port_arbiter.sv
// Arbitrates fetch and data ports onto one
// req/ack memory, stalling the CPU meanwhile.
module mem_port_arbiter
  import cpu_mem_pkg::*;
#(
  parameter int ADDR_W  = ADDR_W_DEF,
  parameter int DATA_W  = DATA_W_DEF,
  parameter int TIMEOUT = TIMEOUT_DEF
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              if_req,
  input  logic [ADDR_W-1:0] if_addr,
  output logic [DATA_W-1:0] if_rdata,
  input  logic              d_read,
  input  logic              d_write,
  input  logic [ADDR_W-1:0] d_addr,
  input  logic [DATA_W-1:0] d_wdata,
  output logic [DATA_W-1:0] d_rdata,
  output logic              cpu_stall,
  output logic              mem_req,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata,
  input  logic              mem_ack,
  output logic              err
);

  arb_state_t state;
  logic       if_done;
  logic       d_done;
  logic       d_pend;
  logic       i_pend;
  logic       busy;
  logic       issue;
  logic       wd_clr;
  logic       wd_exp;

  assign d_pend    = (d_read | d_write) & ~d_done;
  assign i_pend    = if_req & ~if_done;
  assign cpu_stall = d_pend | i_pend;

  assign busy   = (state != IDLE);
  // busy with mem_req low is the gap cycle
  // before a back-to-back request goes out
  assign issue  = busy & ~mem_req;
  assign wd_clr = ~busy | issue | mem_ack;

  ack_watchdog #(
    .TIMEOUT (TIMEOUT)
  ) u_wd (
    .clk     (clk),
    .rst     (rst),
    .clr     (wd_clr),
    .en      (busy),
    .expired (wd_exp)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state     <= IDLE;
      mem_req   <= 1'b0;
      mem_we    <= 1'b0;
      mem_addr  <= '0;
      mem_wdata <= '0;
      if_rdata  <= '0;
      d_rdata   <= '0;
      if_done   <= 1'b0;
      d_done    <= 1'b0;
      err       <= 1'b0;
    end else begin
      if (!cpu_stall) begin
        if_done <= 1'b0;
        d_done  <= 1'b0;
      end
      unique case (state)
        IDLE: begin
          if (d_pend) begin
            state     <= D_BUSY;
            mem_req   <= 1'b1;
            mem_we    <= d_write;
            mem_addr  <= d_addr;
            mem_wdata <= d_wdata;
          end else if (i_pend) begin
            state    <= I_BUSY;
            mem_req  <= 1'b1;
            mem_we   <= 1'b0;
            mem_addr <= if_addr;
          end
        end
        D_BUSY: begin
          if (!mem_req) begin
            mem_req   <= 1'b1;
            mem_we    <= d_write;
            mem_addr  <= d_addr;
            mem_wdata <= d_wdata;
          end else if (mem_ack) begin
            mem_req <= 1'b0;
            d_done  <= 1'b1;
            if (!mem_we) begin
              d_rdata <= mem_rdata;
            end
            state <= i_pend ? I_BUSY : IDLE;
          end else if (wd_exp) begin
            mem_req <= 1'b0;
            d_done  <= 1'b1;
            err     <= 1'b1;
            state   <= IDLE;
          end
        end
        I_BUSY: begin
          if (!mem_req) begin
            mem_req  <= 1'b1;
            mem_we   <= 1'b0;
            mem_addr <= if_addr;
          end else if (mem_ack) begin
            mem_req  <= 1'b0;
            if_done  <= 1'b1;
            if_rdata <= mem_rdata;
            state    <= d_pend ? D_BUSY : IDLE;
          end else if (wd_exp) begin
            mem_req <= 1'b0;
            if_done <= 1'b1;
            err     <= 1'b1;
            state   <= IDLE;
          end
        end
        default: begin
          state   <= IDLE;
          mem_req <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Scoreboard bench for mem_port_arbiter with a
// latency-configurable memory model.
module tb_mem_port_arbiter;
  import cpu_mem_pkg::*;

  typedef struct {
    logic [31:0] addr;
    logic        we;
    logic [31:0] wdata;
  } req_t;

  logic        clk = 1'b0;
  logic        rst;
  logic        if_req;
  logic [31:0] if_addr;
  logic [31:0] if_rdata;
  logic        d_read;
  logic        d_write;
  logic [31:0] d_addr;
  logic [31:0] d_wdata;
  logic [31:0] d_rdata;
  logic        cpu_stall;
  logic        mem_req;
  logic        mem_we;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic [31:0] mem_rdata = '0;
  logic        mem_ack = 1'b0;
  logic        err;

  int   checks = 0;
  int   errors = 0;
  int   lat = 1;
  int   mcnt = 0;
  bit   never_ack = 1'b0;
  bit   spur = 1'b0;
  req_t q[$];

  always #5 clk = ~clk;

  mem_port_arbiter #(
    .ADDR_W  (32),
    .DATA_W  (32),
    .TIMEOUT (8)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .if_req    (if_req),
    .if_addr   (if_addr),
    .if_rdata  (if_rdata),
    .d_read    (d_read),
    .d_write   (d_write),
    .d_addr    (d_addr),
    .d_wdata   (d_wdata),
    .d_rdata   (d_rdata),
    .cpu_stall (cpu_stall),
    .mem_req   (mem_req),
    .mem_we    (mem_we),
    .mem_addr  (mem_addr),
    .mem_wdata (mem_wdata),
    .mem_rdata (mem_rdata),
    .mem_ack   (mem_ack),
    .err       (err)
  );

  function automatic logic [31:0] rd(input logic [31:0] a);
    case (a)
      32'h10:  return 32'h8C010004;
      32'h20:  return 32'h00221820;
      32'h100: return 32'hDEADBEEF;
      default: return a ^ 32'hA5A50000;
    endcase
  endfunction

  task automatic chk(input string name,
                     input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h want %h", name, act, exp);
    end
  endtask

  // memory model: ack arrives lat cycles after req rises
  always begin
    @(posedge clk);
    #1;
    if (!rst) begin
      mem_ack = 1'b0;
      mcnt = 0;
    end else if (mem_ack) begin
      mem_ack = 1'b0;
      mem_rdata = '0;
      mcnt = 0;
    end else if (spur && !mem_req) begin
      mem_ack = 1'b1;
      mem_rdata = 32'h11111111;
    end else if (mem_req && !never_ack) begin
      mcnt++;
      if (mcnt == lat + 1) begin
        mem_ack = 1'b1;
        mem_rdata = rd(mem_addr);
      end
    end else begin
      mcnt = 0;
    end
  end

  always @(negedge clk) begin
    if (rst === 1'b1 && mem_req === 1'b1) begin
      if (q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL req_unexpected: got addr %h want none",
                 mem_addr);
      end else begin
        chk("req_addr", mem_addr, q[0].addr);
        chk("req_we", 32'(mem_we), 32'(q[0].we));
        if (q[0].we)
          chk("req_wdata", mem_wdata, q[0].wdata);
      end
    end
  end

  always @(posedge clk) begin
    if (rst === 1'b1 && mem_req === 1'b1 &&
        mem_ack === 1'b1 && q.size() > 0)
      void'(q.pop_front());
  end

  task automatic access(input bit ir,
                        input logic [31:0] ia,
                        input bit dr,
                        input bit dw,
                        input logic [31:0] da,
                        input logic [31:0] wd,
                        input int l,
                        output int n);
    req_t e;
    @(negedge clk);
    lat = l;
    if (dr || dw) begin
      e.addr = da;
      e.we = dw;
      e.wdata = wd;
      q.push_back(e);
    end
    if (ir) begin
      e.addr = ia;
      e.we = 1'b0;
      e.wdata = '0;
      q.push_back(e);
    end
    if_req = ir;
    if_addr = ia;
    d_read = dr;
    d_write = dw;
    d_addr = da;
    d_wdata = wd;
    #1;
    n = 0;
    while (cpu_stall && n < 200) begin
      n++;
      @(negedge clk);
      #1;
    end
    if_req = 1'b0;
    d_read = 1'b0;
    d_write = 1'b0;
  endtask

  initial begin
    int   n;
    int   k;
    req_t e;
    rst = 1'b0;
    if_req = 1'b0;
    if_addr = '0;
    d_read = 1'b0;
    d_write = 1'b0;
    d_addr = '0;
    d_wdata = '0;
    repeat (2) @(negedge clk);
    chk("rst_mem_req", 32'(mem_req), 0);
    chk("rst_mem_addr", mem_addr, 0);
    chk("rst_if_rdata", if_rdata, 0);
    chk("rst_d_rdata", d_rdata, 0);
    chk("rst_err", 32'(err), 0);
    chk("rst_stall", 32'(cpu_stall), 0);
    rst = 1'b1;

    // reset while a fetch is outstanding
    @(negedge clk);
    never_ack = 1'b1;
    e.addr = 32'h40;
    e.we = 1'b0;
    e.wdata = '0;
    q.push_back(e);
    if_req = 1'b1;
    if_addr = 32'h40;
    k = 0;
    while (!mem_req && k < 20) begin
      k++;
      @(negedge clk);
    end
    chk("midrst_req_up", 32'(mem_req), 1);
    #2;
    rst = 1'b0;
    #1;
    chk("midrst_req", 32'(mem_req), 0);
    chk("midrst_addr", mem_addr, 0);
    chk("midrst_we", 32'(mem_we), 0);
    chk("midrst_if_rdata", if_rdata, 0);
    q.delete();
    if_req = 1'b0;
    never_ack = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    chk("midrst_state", 32'(dut.state), 32'(IDLE));
    chk("midrst_stall", 32'(cpu_stall), 0);

    access(1, 32'h10, 0, 0, 0, 0, 1, n);
    chk("fetch_stall", n, 3);
    chk("fetch_if_rdata", if_rdata, 32'h8C010004);
    chk("fetch_d_rdata", d_rdata, 0);

    access(1, 32'h20, 1, 0, 32'h100, 0, 2, n);
    chk("both_stall", n, 8);
    chk("both_d_rdata", d_rdata, 32'hDEADBEEF);
    chk("both_if_rdata", if_rdata, 32'h00221820);

    access(1, 32'h24, 0, 1, 32'h200, 32'h12345678, 1, n);
    chk("wr_stall", n, 6);
    chk("wr_d_rdata", d_rdata, 32'hDEADBEEF);
    chk("wr_if_rdata", if_rdata, 32'hA5A50024);

    access(0, 0, 1, 1, 32'h300, 32'hCAFEF00D, 1, n);
    chk("rw_stall", n, 3);
    chk("rw_we", 32'(mem_we), 1);
    chk("rw_d_rdata", d_rdata, 32'hDEADBEEF);

    access(0, 0, 1, 0, 32'h104, 0, 1, n);
    chk("rd_stall", n, 3);
    chk("rd_d_rdata", d_rdata, 32'hA5A50104);

    // no ack ever: watchdog abandons the fetch
    never_ack = 1'b1;
    access(1, 32'h50, 0, 0, 0, 0, 1, n);
    chk("to_stall", n, 9);
    chk("to_err", 32'(err), 1);
    chk("to_req", 32'(mem_req), 0);
    chk("to_if_rdata", if_rdata, 32'hA5A50024);
    q.delete();
    never_ack = 1'b0;

    access(1, 32'h60, 0, 0, 0, 0, 1, n);
    chk("post_to_stall", n, 3);
    chk("post_to_if_rdata", if_rdata, 32'hA5A50060);
    chk("post_to_err", 32'(err), 1);

    // stray acks while idle must not disturb anything
    @(negedge clk);
    spur = 1'b1;
    repeat (4) @(negedge clk);
    spur = 1'b0;
    repeat (2) @(negedge clk);
    chk("idle_ack_if", if_rdata, 32'hA5A50060);
    chk("idle_ack_d", d_rdata, 32'hA5A50104);
    chk("idle_ack_req", 32'(mem_req), 0);
    chk("idle_ack_state", 32'(dut.state), 32'(IDLE));

    rst = 1'b0;
    #1;
    chk("final_rst_err", 32'(err), 0);

    $display("Simulation finished: %0d checks, %0d errors",
             checks, errors);
    $finish;
  end

endmodule
